// File: rtl/div_iter_pkg.sv
// div_iter shared types and helpers.
// Magnitude helpers used for sign handling around the restoring core.
package div_iter_pkg;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  function automatic logic [DIV_WIDTH-1:0] neg_w(
    input logic [DIV_WIDTH-1:0] x
  );
    return ~x + 32'd1;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] abs_w(
    input logic [DIV_WIDTH-1:0] x,
    input logic                 sgn
  );
    return (sgn && x[DIV_WIDTH-1]) ? neg_w(x) : x;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle; signs fixed on entry to DONE.
module div_iter
  import div_iter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [DIV_WIDTH-1:0]   a,
  input  logic [DIV_WIDTH-1:0]   b,
  input  logic                   valid,
  input  logic                   signed_div,
  output logic                   stall,
  output logic [2*DIV_WIDTH-1:0] result
);

  div_state_t state, state_d;

  logic [32:0] rem;
  logic [31:0] dq;
  logic [31:0] dvs;
  logic [4:0]  count;
  logic        q_neg;
  logic        r_neg;

  logic        start;
  logic        last;
  logic [33:0] trial;
  logic [32:0] rem_n;
  logic [31:0] dq_n;

  // Trial subtract on the shifted remainder; borrow means restore.
  always_comb begin
    trial = {rem, dq[31]} - {2'b00, dvs};
    if (trial[33]) begin
      rem_n = {rem[31:0], dq[31]};
      dq_n  = {dq[30:0], 1'b0};
    end else begin
      rem_n = trial[32:0];
      dq_n  = {dq[30:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state;
    stall   = 1'b0;
    start   = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid && !flush) begin
          stall   = 1'b1;
          start   = 1'b1;
          state_d = (b == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          if (count == 5'd31) begin
            last    = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      result <= '0;
      rem    <= '0;
      dq     <= '0;
      dvs    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      state <= state_d;
      if (start) begin
        rem   <= '0;
        dq    <= abs_w(a, signed_div);
        dvs   <= abs_w(b, signed_div);
        q_neg <= signed_div & (a[31] ^ b[31]);
        r_neg <= signed_div & a[31];
        count <= '0;
        if (b == '0) result <= {a, DIV_ZERO_QUO};
      end else if (state == BUSY && !flush) begin
        rem   <= rem_n;
        dq    <= dq_n;
        count <= count + 5'd1;
        if (last) begin
          result <= {r_neg ? neg_w(rem_n[31:0]) : rem_n[31:0],
                     q_neg ? neg_w(dq_n) : dq_n};
        end
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter.
// Driver queues model results; monitor checks them at completion.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid;
  logic        signed_div;
  logic        stall;
  logic [63:0] result;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] last_exp = '0;
  int          run = 0;

  div_iter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .a          (a),
    .b          (b),
    .valid      (valid),
    .signed_div (signed_div),
    .stall      (stall),
    .result     (result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        s
  );
    longint nx, ny, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      nx = longint'(signed'(x));
      ny = longint'(signed'(y));
    end else begin
      nx = longint'({32'd0, x});
      ny = longint'({32'd0, y});
    end
    q = nx / ny;
    r = nx % ny;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check64(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: a completion is the first non-stalled cycle of a held request.
  always @(negedge clk) begin
    if (valid && !flush && !rst) begin
      if (stall) begin
        run++;
      end else if (run > 0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got result %h expected none", result);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check64("result", result, e.res);
          n_checks++;
          if (run != e.lat) begin
            n_errors++;
            $display("FAIL latency: got %0d stall cycles expected %0d",
                     run, e.lat);
          end
        end
        run = 0;
      end
    end else begin
      run = 0;
    end
  end

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb,
                       input logic ts);
    @(posedge clk);
    #1;
    a          = ta;
    b          = tb;
    signed_div = ts;
    valid      = 1'b1;
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                        input logic ts);
    exp_t e;
    int   n;
    e.res = model(ta, tb, ts);
    e.lat = (tb == 32'd0) ? 1 : 33;
    sb_q.push_back(e);
    last_exp = e.res;
    drive(ta, tb, ts);
    n = 0;
    @(negedge clk);
    while (stall && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: stall still %b after %0d cycles expected 0",
               stall, n);
    end
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    valid      = 1'b0;
    signed_div = 1'b0;
    a          = '0;
    b          = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("reset_stall", stall, 1'b0);
    check64("reset_result", result, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd5, 32'd0, 1'b1);
    run_op(32'hFFFF_FFF0, 32'd0, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    go_idle();

    // Flush ten cycles into an operation.
    drive(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check1("flush_stall", stall, 1'b0);
    check64("flush_result", result, last_exp);
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check1("flush_idle_stall", stall, 1'b0);
    check64("flush_hold_result", result, last_exp);
    run_op(32'd9, 32'd3, 1'b0);
    go_idle();

    // Reset five cycles into an operation.
    drive(32'd50, 32'd3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check1("midrst_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check64("midrst_result", result, 64'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    run_op(32'd1000, 32'd10, 1'b0);
    go_idle();

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      int          sel;
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (sel == 3 && rb == 32'd0) rb = 32'd3;
      run_op(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0",
               sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 divider serving the EX stage of the MIPS pipeline for DIV and DIVU. It produces the 64-bit {remainder, quotient} word that the ALU forwards on its 64-bit result toward the HI/LO register, and it holds the pipeline with `stall` while it works. It computes one quotient bit per cycle on magnitudes, with sign correction applied at completion.

## Interface
- No parameters; the data width is fixed at 32.
- `clk`     in   1   Sole clock; all state updates on its rising edge.
- `rst`     in   1   Reset is synchronous and active-high.
- `flush`   in   1   EX-stage flush; abandons any operation in flight.
- `a`       in   32  Dividend (rs).
- `b`       in   32  Divisor (rt).
- `valid`   in   1   A DIV or DIVU occupies EX. EX holds it high, with stable `a`, `b`, `signed_div`, for as long as `stall` is high.
- `signed_div` in 1  1 = DIV (two's complement), 0 = DIVU.
- `stall`   out  1   Freeze request to the pipeline.
- `result`  out  64  {remainder[63:32], quotient[31:0]}.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - `stall = valid & ~flush`.
  - On `valid & ~flush`, capture |a|, |b|, the quotient sign (a[31]^b[31], signed only) and the remainder sign (a[31], signed only).
  - If b == 0, go to DONE. Otherwise go to BUSY with count = 0.
- **BUSY:**
  - `stall = ~flush`.
  - Each cycle performs one restoring step: shift {partial remainder, dividend} left by 1, then trial-subtract the divisor from the 33-bit partial remainder. If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - The count increments every cycle. After the step with count == 31, go to DONE.
- **DONE:**
  - `stall = 0`. `result` is registered and already final in this cycle.
  - The next state is always IDLE, even if `valid` is high. The pipeline advances on this cycle, so a `valid` seen in the following IDLE cycle belongs to a new instruction.
- **Sign fix (on entry to DONE):**
  - Negate the quotient if its sign flag is set.
  - Negate the remainder if its sign flag is set.
  - The remainder takes the dividend's sign.
- **Divide by zero:** `result = {a, 32'hFFFF_FFFF}` for both signed and unsigned operation.
- **Overflow case:** signed 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000 and remainder 0. This falls out of the magnitude path with no special case.
- **Flush:** any state with `flush = 1` goes to IDLE next cycle. `stall` is 0 in that cycle, and `result` is not updated.
- **`result` register:** changes only on entry to DONE. Otherwise it holds its last value.
- **Reset:**
  - State IDLE, count 0, `result` 0.
  - `stall` is forced to 0 while `rst` is high.
  - Reset mid-operation discards the operation.

## Timing
- Cycle T is the first IDLE cycle with `valid` (b ≠ 0):
  - `stall` is high for T..T+32 (33 cycles).
  - BUSY occupies T+1..T+32.
  - DONE is at T+33, with `stall = 0` and `result` valid.
- Divide by zero: `stall` is high only in T; DONE is at T+1.
- Back-to-back divides: the next operation can start at T+34.
- `stall` is combinational from state, `valid` and `flush`. All other outputs are registered.

## Structure
- **Shared package:**
  - State enum `div_state_t` {IDLE, BUSY, DONE}.
  - `DIV_WIDTH = 32`.
  - `DIV_ZERO_QUO = 32'hFFFF_FFFF`.
- **Sub-modules:** none. The abs/negate logic is two small inline functions in the package.
- **Datapath registers:**
  - 33-bit partial remainder.
  - 32-bit dividend/quotient shift register.
  - 32-bit divisor magnitude.
  - 5-bit count.
  - 2 sign flags.
  - 64-bit `result`.

## Test plan
- **Unsigned divide:** DIVU a=100, b=7 at T → `stall` high T..T+32; `result` = {32'd2, 32'd14} at T+33.
- **Signed divide:** DIV a=-7 (0xFFFF_FFF9), b=2 → quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF.
- **Signed overflow:** DIV a=0x8000_0000, b=0xFFFF_FFFF → quotient 0x8000_0000, remainder 0. DIVU with the same operands → quotient 0, remainder 0x8000_0000.
- **Divide by zero:** DIV a=5, b=0 → `stall` high only at T; `result` = {32'd5, 32'hFFFF_FFFF} at T+1.
- **Flush:** flush at T+10 → `stall` 0 at T+10, IDLE at T+11, `result` keeps its prior value. Then `valid` at T+12 with a=9, b=3 → {0, 3} at T+45.
- **Reset mid-operation:** `rst` at T+5 → `stall` 0, `result` 0, state IDLE. The first operation after reset completes with full 33-cycle latency.
